// File: rtl/psi_set_extract.sv
// psi_set_extract: converts the PSI membership bitmask into a stream of element
// indices (lowest first). It then reports the cardinality and pulses done.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge where
// valid && ready are both high. The input side is ready only in IDLE. The output
// side holds out_idx/out_last/count stable while out_valid && !out_ready. valid
// never depends on ready within the same cycle.
module psi_set_extract #(
  parameter  int W  = 10,
  localparam int IW = $clog2(W),
  localparam int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_mask,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic [CW-1:0] count,
  output logic          done
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // state is the observable FSM state for checkers bound to this block
  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   wm;
  logic           done_nxt;
  logic           capture;
  logic           pop;
  logic           single;
  logic [IW-1:0]  low_idx;

  // Priority encoder on the working mask: the lowest set bit wins.
  always_comb begin
    low_idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (wm[i]) low_idx = IW'(i);
    end
  end

  // Exactly one bit left: clearing the lowest bit would leave zero.
  always_comb begin
    single = (wm != '0) && ((wm & (wm - W'(1))) == '0);
  end

  // Next-state and handshake outputs; empty masks finish straight from IDLE.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_idx   = low_idx;
    capture   = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        capture  = in_valid;
        if (in_valid) begin
          if (in_mask != '0) state_nxt = SCAN;
          else               done_nxt  = 1'b1;
        end
      end
      SCAN: begin
        out_valid = 1'b1;
        out_last  = single;
        pop       = out_ready;
        if (out_ready && single) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, working mask, cardinality and done registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wm    <= '0;
      count <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (capture) begin
        wm    <= in_mask;
        count <= '0;
      end else if (pop) begin
        wm    <= wm & ~(W'(1) << low_idx);
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_psi_set_extract.sv
// tb_psi_set_extract: randomized and directed stimulus against a queue-based
// reference model of the index stream, cardinality and done pulse.
module tb_psi_set_extract;

  localparam int W  = 10;
  localparam int IW = $clog2(W);
  localparam int CW = $clog2(W + 1);

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_mask;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic [CW-1:0] count;
  logic          done;

  always #5 clk = ~clk;

  psi_set_extract #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .count     (count),
    .done      (done)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [IW-1:0] exp_q[$];     // indices still to be emitted for the current mask
  int            exp_count;
  logic          exp_done;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_count = 0;
    exp_done  = 1'b0;
  endtask

  // One clock cycle: inputs are already driven; compare outputs, advance the
  // model by what the coming edge does, then move to the next negedge.
  task automatic step();
    logic nxt_done;
    #1;
    chk("in_ready",  32'(in_ready),  32'(exp_q.size() == 0));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    chk("done",      32'(done),      32'(exp_done));
    chk("count",     32'(count),     32'(exp_count));
    if (exp_q.size() != 0) begin
      chk("out_idx",  32'(out_idx),  32'(exp_q[0]));
      chk("out_last", 32'(out_last), 32'(exp_q.size() == 1));
    end
    nxt_done = 1'b0;
    if (rst) begin
      exp_q.delete();
      exp_count = 0;
    end else if (exp_q.size() != 0) begin
      if (out_ready) begin
        void'(exp_q.pop_front());
        exp_count++;
        if (exp_q.size() == 0) nxt_done = 1'b1;
      end
    end else if (in_valid) begin
      exp_count = 0;
      for (int k = 0; k < W; k++) if (in_mask[k]) exp_q.push_back(IW'(k));
      if (in_mask == '0) nxt_done = 1'b1;
    end
    exp_done = nxt_done;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  // mode 0: ready always; 1: ready pattern 1,0,0; 2: random ready;
  // 3: ready always plus in_valid noise while streaming
  task automatic run_mask(input logic [W-1:0] mask, input int mode);
    int cyc;
    in_valid  = 1'b1;
    in_mask   = mask;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      case (mode)
        1:       out_ready = (cyc % 3 == 0);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      if (mode == 3) begin
        in_valid = 1'b1;
        in_mask  = W'($urandom_range(0, (1 << W) - 1));
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("drain_timeout", 32'(cyc < 200), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mask   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    model_clear();
    rst = 1'b0;
    #1;
    chk("rst_out_idx",  32'(out_idx),  32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    step();

    // directed cases
    run_mask(10'b10_0100_0101, 0);
    run_mask(10'b10_0100_0101, 1);
    run_mask(10'b00_0000_0000, 0);
    run_mask(10'h3FF, 0);
    run_mask(10'b10_0000_0000, 0);   // captured in the cycle done is high
    run_mask(10'b01_1011_0010, 3);
    step();

    // reset after two indices of 10'b11110000
    in_valid  = 1'b1;
    in_mask   = 10'b00_1111_0000;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    do_reset();
    #1;
    chk("rst_mid_out_idx", 32'(out_idx), 32'd0);
    step();
    run_mask(10'b00_0001_1000, 2);
    step();

    // randomized masks and modes
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] m;
      m = W'($urandom_range(0, (1 << W) - 1));
      if ($urandom_range(0, 7) == 0) m = '0;
      run_mask(m, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) step();
    end
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
